icache_ctrl: RTL and testbench

//  Responder side of the fetch-unit line-read handshake: accepts read_req_i + PC, returns a full cache line

---
 rtl/mmm_pkg.sv | 30 +++
 rtl/icache_store.sv | 56 +++++
 rtl/icache_ctrl.sv | 146 ++++++++++++++
 tb/tb_icache_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// ---------------------------------------------------------------------------
// mmm_pkg
// Shared types and constants for the fetch path: machine width, I-cache line
// geometry, the line-read response record and the I-cache controller states.
// ---------------------------------------------------------------------------
package mmm_pkg;

   localparam int XLEN            = 32;
   localparam int ICACHE_OFFSET   = 4;
   localparam int ICACHE_LINE_LEN = 8 * (2 ** ICACHE_OFFSET);

   typedef struct packed {
      logic [ICACHE_LINE_LEN-1:0] line;
      logic [XLEN-1:0]            pc;
   } icache_out_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      MISS_REQ  = 3'd2,
      MISS_WAIT = 3'd3,
      RESP      = 3'd4
   } icache_ctrl_state_t;

   // Clear the byte-offset bits to get the line base address.
   function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:ICACHE_OFFSET], {ICACHE_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/icache_store.sv
// ---------------------------------------------------------------------------
// icache_store
// Direct-mapped line store: tag, data and valid arrays.
//   clk_i, rst_n_i    clock, async active-low reset (valid bits only)
//   rd_idx_i          combinational read index
//   rd_valid_o/_tag_o/_data_o   contents of the indexed set
//   wr_en_i, wr_idx_i, wr_tag_i, wr_data_i   synchronous line fill
//   clear_i           synchronous clear of every valid bit (beats a fill)
// ---------------------------------------------------------------------------
module icache_store
   import mmm_pkg::*;
#(
   parameter int SETS  = 16,
   parameter int IDX_W = $clog2(SETS),
   parameter int TAG_W = XLEN - IDX_W - ICACHE_OFFSET
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [IDX_W-1:0]           rd_idx_i,
   output logic                       rd_valid_o,
   output logic [TAG_W-1:0]           rd_tag_o,
   output logic [ICACHE_LINE_LEN-1:0] rd_data_o,
   input  logic                       wr_en_i,
   input  logic [IDX_W-1:0]           wr_idx_i,
   input  logic [TAG_W-1:0]           wr_tag_i,
   input  logic [ICACHE_LINE_LEN-1:0] wr_data_i,
   input  logic                       clear_i
);

   logic [SETS-1:0]            valid_q;
   logic [TAG_W-1:0]           tag_q  [SETS];
   logic [ICACHE_LINE_LEN-1:0] data_q [SETS];

   // Clear has priority so a fence.i racing a refill leaves the line invalid.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
      end else if (clear_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
// Responder for the fetch-unit line-read handshake, backed by a direct-mapped
// read-only line store refilled from next-level memory.
//   clk_i, rst_n_i       clock, async active-low reset
//   flush_i              abort the current fetch request
//   invalidate_i         clear all line valid bits
//   read_req_i/addr_i    line read request and PC
//   read_done_o          one-cycle pulse, cache_out_o holds {line, pc}
//   mem_req_*            refill request (valid/ready, line-aligned address)
//   mem_resp_*           single-beat refill data
//
// state     | meaning
// IDLE      | waiting for read_req_i; only state that accepts a request
// LOOKUP    | tag compare on the latched PC
// MISS_REQ  | refill request presented, waiting for mem_req_ready_i
// MISS_WAIT | waiting for refill data; kill_q drops the response
// RESP      | read_done_o asserted for one cycle
// ---------------------------------------------------------------------------
module icache_ctrl
   import mmm_pkg::*;
#(
   parameter int ICACHE_SETS = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       flush_i,
   input  logic                       invalidate_i,
   input  logic                       read_req_i,
   input  logic [XLEN-1:0]            read_addr_i,
   output logic                       read_done_o,
   output icache_out_t                cache_out_o,
   output logic                       mem_req_valid_o,
   input  logic                       mem_req_ready_i,
   output logic [XLEN-1:0]            mem_req_addr_o,
   input  logic                       mem_resp_valid_i,
   input  logic [ICACHE_LINE_LEN-1:0] mem_resp_line_i
);

   localparam int INDEX = $clog2(ICACHE_SETS);
   localparam int TAG_W = XLEN - INDEX - ICACHE_OFFSET;

   icache_ctrl_state_t state_q;
   logic [XLEN-1:0]    addr_q;
   logic               kill_q;
   icache_out_t        cache_out_q;
   logic               mem_req_valid_q;
   logic [XLEN-1:0]    mem_req_addr_q;

   logic [INDEX-1:0]           idx;
   logic [TAG_W-1:0]           tag;
   logic                       st_valid;
   logic [TAG_W-1:0]           st_tag;
   logic [ICACHE_LINE_LEN-1:0] st_data;
   logic                       hit;
   logic                       fill;

   assign idx  = addr_q[ICACHE_OFFSET +: INDEX];
   assign tag  = addr_q[XLEN-1 -: TAG_W];
   assign hit  = st_valid && (st_tag == tag);
   // The fill is written even when the request was killed, so the line stays usable.
   assign fill = (state_q == MISS_WAIT) && mem_resp_valid_i;

   icache_store #(
      .SETS (ICACHE_SETS)
   ) u_store (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .rd_idx_i   (idx),
      .rd_valid_o (st_valid),
      .rd_tag_o   (st_tag),
      .rd_data_o  (st_data),
      .wr_en_i    (fill),
      .wr_idx_i   (idx),
      .wr_tag_i   (tag),
      .wr_data_i  (mem_resp_line_i),
      .clear_i    (invalidate_i)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         kill_q          <= 1'b0;
         cache_out_q     <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (read_req_i && !flush_i) begin
                  addr_q  <= read_addr_i;
                  state_q <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else if (hit) begin
                  cache_out_q <= '{line: st_data, pc: addr_q};
                  state_q     <= RESP;
               end else begin
                  mem_req_addr_q  <= line_align(addr_q);
                  mem_req_valid_q <= 1'b1;
                  state_q         <= MISS_REQ;
               end
            end
            MISS_REQ: begin
               // Request stays up through a flush; the refill is just not answered.
               if (flush_i) begin
                  kill_q <= 1'b1;
               end
               if (mem_req_ready_i) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               if (mem_resp_valid_i) begin
                  if (kill_q || flush_i) begin
                     kill_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cache_out_q <= '{line: mem_resp_line_i, pc: addr_q};
                     state_q     <= RESP;
                  end
               end else if (flush_i) begin
                  kill_q <= 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign read_done_o     = (state_q == RESP) && !flush_i;
   assign cache_out_o     = cache_out_q;
   assign mem_req_valid_o = mem_req_valid_q;
   assign mem_req_addr_o  = mem_req_addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
   import mmm_pkg::*;

   logic                       clk_i = 1'b0;
   logic                       rst_n_i = 1'b0;
   logic                       flush_i = 1'b0;
   logic                       invalidate_i = 1'b0;
   logic                       read_req_i = 1'b0;
   logic [XLEN-1:0]            read_addr_i = '0;
   logic                       read_done_o;
   icache_out_t                cache_out_o;
   logic                       mem_req_valid_o;
   logic                       mem_req_ready_i = 1'b0;
   logic [XLEN-1:0]            mem_req_addr_o;
   logic                       mem_resp_valid_i = 1'b0;
   logic [ICACHE_LINE_LEN-1:0] mem_resp_line_i = '0;

   int errors = 0;
   int checks = 0;

   icache_ctrl #(.ICACHE_SETS(16)) dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .flush_i          (flush_i),
      .invalidate_i     (invalidate_i),
      .read_req_i       (read_req_i),
      .read_addr_i      (read_addr_i),
      .read_done_o      (read_done_o),
      .cache_out_o      (cache_out_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_line_i  (mem_resp_line_i)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [127:0] L1 = 128'h1111_0001_1111_0002_1111_0003_1111_0004;
   localparam logic [127:0] L2 = 128'h2222_aaaa_2222_bbbb_2222_cccc_2222_dddd;
   localparam logic [127:0] L3 = 128'h3333_0000_dead_beef_3333_0000_cafe_f00d;
   localparam logic [127:0] L4 = 128'hffff_ffff_0000_0000_ffff_ffff_0000_0001;
   localparam logic [127:0] L5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
   localparam logic [127:0] L6 = 128'h6666_1234_6666_5678_6666_9abc_6666_def0;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] line;
      bit           hit;
      int           lat;
      logic [31:0]  mem_addr;
      logic [127:0] exp_line;
   } vec_t;

   vec_t vecs[10];

   function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issues one request from IDLE (called #1 after an edge) and plays memory.
   task automatic do_req(input string nm, input logic [31:0] addr, input bit exp_hit,
                         input logic [127:0] line, input int lat, input logic [31:0] exp_maddr,
                         input logic [127:0] exp_line, input bit inv_on_resp);
      int c = 0;
      int wcnt = 0;
      int hs = 0;
      int req_c = -1;
      int resp_c = -1;
      bit done = 0;
      logic [31:0] a0 = '0;
      read_req_i  = 1'b1;
      read_addr_i = addr;
      while (!done && c < 100) begin
         tick();
         c++;
         mem_req_ready_i  = 1'b0;
         mem_resp_valid_i = 1'b0;
         invalidate_i     = 1'b0;
         if (read_done_o) begin
            done = 1;
         end else if (mem_req_valid_o) begin
            if (req_c < 0) begin
               req_c = c;
               a0    = mem_req_addr_o;
            end else begin
               chk({nm, " req_addr_stable"}, mem_req_addr_o, exp_maddr);
            end
            if (wcnt >= lat) begin
               mem_req_ready_i = 1'b1;
               hs++;
            end else begin
               wcnt++;
            end
         end else if (hs > 0 && resp_c < 0) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_line_i  = line;
            invalidate_i     = inv_on_resp;
            resp_c           = c;
         end
      end
      read_req_i = 1'b0;
      chk({nm, " done_seen"}, done, 1'b1);
      if (exp_hit) begin
         chk({nm, " hit_latency"}, c, 2);
         chk({nm, " hit_no_mem_req"}, req_c, -1);
      end else begin
         chk({nm, " miss_req_cycle"}, req_c, 2);
         chk({nm, " miss_req_addr"}, a0, exp_maddr);
         chk({nm, " handshakes"}, hs, 1);
         chk({nm, " done_after_resp"}, c, resp_c + 1);
      end
      chk({nm, " line"}, cache_out_o.line, exp_line);
      chk({nm, " pc"}, cache_out_o.pc, addr);
      tick();
      chk({nm, " done_pulse"}, read_done_o, 1'b0);
      chk({nm, " out_stable"}, cache_out_o, {exp_line, addr});
   endtask

   initial begin
      vecs[0] = '{32'h0000_1004, L1, 0, 0, 32'h0000_1000, L1};
      vecs[1] = '{32'h0000_1008, '0, 1, 0, 32'h0,         L1};
      vecs[2] = '{32'h0000_1100, L2, 0, 0, 32'h0000_1100, L2};
      vecs[3] = '{32'h0000_1000, L1, 0, 0, 32'h0000_1000, L1};
      vecs[4] = '{32'h0000_100C, '0, 1, 0, 32'h0,         L1};
      vecs[5] = '{32'h0000_3A5C, L3, 0, 5, 32'h0000_3A50, L3};
      vecs[6] = '{32'h0000_3A50, '0, 1, 0, 32'h0,         L3};
      vecs[7] = '{32'hFFFF_FFF0, L4, 0, 2, 32'hFFFF_FFF0, L4};
      vecs[8] = '{32'hFFFF_FFFF, '0, 1, 0, 32'h0,         L4};
      vecs[9] = '{32'h0000_1008, '0, 1, 0, 32'h0,         L1};

      // reset
      repeat (2) tick();
      chk("rst done", read_done_o, 1'b0);
      chk("rst mem_valid", mem_req_valid_o, 1'b0);
      chk("rst mem_addr", mem_req_addr_o, 32'h0);
      chk("rst cache_out", cache_out_o, 160'h0);
      rst_n_i = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hit, vecs[i].line,
                vecs[i].lat, vecs[i].mem_addr, vecs[i].exp_line, 1'b0);
      end

      // flush while in MISS_WAIT: no response, but the fill lands
      read_req_i  = 1'b1;
      read_addr_i = 32'h0000_2004;
      begin
         int c = 0;
         while (!mem_req_valid_o && c < 10) begin
            tick();
            c++;
         end
         chk("fmw req_seen", mem_req_valid_o, 1'b1);
         chk("fmw req_addr", mem_req_addr_o, 32'h0000_2000);
      end
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      chk("fmw valid_dropped", mem_req_valid_o, 1'b0);
      flush_i    = 1'b1;
      read_req_i = 1'b0;
      tick();
      flush_i = 1'b0;
      chk("fmw no_done0", read_done_o, 1'b0);
      tick();
      mem_resp_valid_i = 1'b1;
      mem_resp_line_i  = L6;
      tick();
      mem_resp_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fmw no_done", read_done_o, 1'b0);
         chk("fmw no_req", mem_req_valid_o, 1'b0);
         tick();
      end
      do_req("fmw_hit", 32'h0000_2008, 1, '0, 0, 32'h0, L6, 1'b0);

      // flush while in LOOKUP on a cold line: nothing happens
      read_req_i  = 1'b1;
      read_addr_i = 32'h0000_5000;
      tick();
      flush_i    = 1'b1;
      read_req_i = 1'b0;
      tick();
      flush_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("flk no_done", read_done_o, 1'b0);
         chk("flk no_req", mem_req_valid_o, 1'b0);
         tick();
      end

      // flush together with a request in IDLE: request ignored
      read_req_i  = 1'b1;
      read_addr_i = 32'h0000_6000;
      flush_i     = 1'b1;
      tick();
      flush_i    = 1'b0;
      read_req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fid no_done", read_done_o, 1'b0);
         chk("fid no_req", mem_req_valid_o, 1'b0);
         tick();
      end

      // flush during RESP suppresses read_done_o
      read_req_i  = 1'b1;
      read_addr_i = 32'h0000_3A54;
      tick();
      tick();
      flush_i    = 1'b1;
      read_req_i = 1'b0;
      #1;
      chk("frs done_masked", read_done_o, 1'b0);
      tick();
      flush_i = 1'b0;
      chk("frs idle_no_done", read_done_o, 1'b0);
      tick();

      // invalidate after fill: previously-hitting line now misses
      invalidate_i = 1'b1;
      tick();
      invalidate_i = 1'b0;
      do_req("inv_miss", 32'h0000_1008, 0, L1, 0, 32'h0000_1000, L1, 1'b0);

      // invalidate coincident with fill: response still delivered, line left invalid
      do_req("invc_fill", 32'h0000_4000, 0, L5, 1, 32'h0000_4000, L5, 1'b1);
      do_req("invc_miss", 32'h0000_4000, 0, L5, 0, 32'h0000_4000, L5, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
